// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup, branch update and invalidate bundle for the BTB
// The pipeline side is the master; the BTB is the slave.
interface branch_target_buffer_if #(
  parameter int PC_W = 32
);
  logic            i_Stall;
  logic            i_Flush;
  logic [PC_W-1:0] i_IF_PC;
  logic            o_IF_Hit;
  logic [PC_W-1:0] o_IF_Target;
  logic            o_PcMatchValid;
  logic [PC_W-1:0] o_PredTarget;
  logic [1:0]      o_CtrlIn;
  logic            i_WriteEnable;
  logic [PC_W-1:0] i_UpdPC;
  logic [PC_W-1:0] i_UpdTarget;
  logic [1:0]      i_CtrlOut;
  logic            i_Invalidate;
  logic            o_Busy;

  modport master (
    output i_Stall, i_Flush, i_IF_PC, i_WriteEnable, i_UpdPC, i_UpdTarget, i_CtrlOut, i_Invalidate,
    input  o_IF_Hit, o_IF_Target, o_PcMatchValid, o_PredTarget, o_CtrlIn, o_Busy
  );

  modport slave (
    input  i_Stall, i_Flush, i_IF_PC, i_WriteEnable, i_UpdPC, i_UpdTarget, i_CtrlOut, i_Invalidate,
    output o_IF_Hit, o_IF_Target, o_PcMatchValid, o_PredTarget, o_CtrlIn, o_Busy
  );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with invalidation sweep
// Combinational write-first lookup for fetch, plus an IF/ID-aligned registered copy.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_mem [ENTRIES];
  logic [PC_W-1:0]   tgt_mem [ENTRIES];
  logic [1:0]        ctr_mem [ENTRIES];

  logic [IDX_W-1:0]  if_idx, upd_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  logic              wr_en, fwd;
  logic              ent_valid;
  logic [TAG_W-1:0]  ent_tag;
  logic [PC_W-1:0]   ent_tgt;
  logic [1:0]        ent_ctr;
  logic              hit;
  logic [PC_W-1:0]   hit_tgt;
  logic [1:0]        hit_ctr;

  logic              match_valid_q;
  logic [PC_W-1:0]   pred_target_q;
  logic [1:0]        ctrl_in_q;

  assign if_idx  = bus.i_IF_PC[IDX_W+1:2];
  assign if_tag  = bus.i_IF_PC[PC_W-1:IDX_W+2];
  assign upd_idx = bus.i_UpdPC[IDX_W+1:2];
  assign upd_tag = bus.i_UpdPC[PC_W-1:IDX_W+2];

  // An invalidate request in the same cycle wins over the update.
  assign wr_en = bus.i_WriteEnable && (state_q == IDLE) && !bus.i_Invalidate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SWEEP)
        sweep_idx_q <= sweep_idx_q + 1'b1;
      else
        sweep_idx_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_Invalidate) state_d = SWEEP;
      SWEEP:   if (sweep_idx_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (state_q == SWEEP) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload storage is never exposed while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= bus.i_UpdTarget;
      ctr_mem[upd_idx] <= bus.i_CtrlOut;
    end
  end

  always_comb begin
    fwd       = wr_en && (upd_idx == if_idx);
    ent_valid = fwd ? 1'b1          : valid_q[if_idx];
    ent_tag   = fwd ? upd_tag       : tag_mem[if_idx];
    ent_tgt   = fwd ? bus.i_UpdTarget : tgt_mem[if_idx];
    ent_ctr   = fwd ? bus.i_CtrlOut : ctr_mem[if_idx];
    hit       = (state_q == IDLE) && ent_valid && (ent_tag == if_tag);
    hit_tgt   = hit ? ent_tgt : '0;
    hit_ctr   = hit ? ent_ctr : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_valid_q <= 1'b0;
      pred_target_q <= '0;
      ctrl_in_q     <= 2'b00;
    end else if (bus.i_Flush) begin
      match_valid_q <= 1'b0;
      pred_target_q <= '0;
      ctrl_in_q     <= 2'b00;
    end else if (!bus.i_Stall) begin
      match_valid_q <= hit;
      pred_target_q <= hit_tgt;
      ctrl_in_q     <= hit_ctr;
    end
  end

  assign bus.o_IF_Hit       = hit;
  assign bus.o_IF_Target    = hit_tgt;
  assign bus.o_PcMatchValid = match_valid_q;
  assign bus.o_PredTarget   = pred_target_q;
  assign bus.o_CtrlIn       = ctrl_in_q;
  assign bus.o_Busy         = (state_q == SWEEP);
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer
// Expected registered outputs are queued as each cycle is driven and popped after the edge.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] t;
    logic [1:0]  c;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  branch_target_buffer_if #(.PC_W(32)) bus ();

  branch_target_buffer #(.ENTRIES(16), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic we, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic [1:0] uctr);
    bus.i_IF_PC       = pc;
    bus.i_WriteEnable = we;
    bus.i_UpdPC       = upc;
    bus.i_UpdTarget   = utgt;
    bus.i_CtrlOut     = uctr;
    #1;
  endtask

  task automatic test_reset();
    bus.i_Stall = 0; bus.i_Flush = 0; bus.i_Invalidate = 0;
    drive(32'h0, 0, 32'h0, 32'h0, 2'b00);
    rst = 1'b1;
    tick();
    total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.o_Busy); end
    total++; if (bus.o_PcMatchValid !== 1'b0) begin bad++; $display("FAIL reset_match got=%0b exp=0", bus.o_PcMatchValid); end
    total++; if (bus.o_PredTarget !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", bus.o_PredTarget); end
    total++; if (bus.o_CtrlIn !== 2'b00) begin bad++; $display("FAIL reset_ctr got=%b exp=00", bus.o_CtrlIn); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    drive(32'h40, 0, 32'h0, 32'h0, 2'b00);
    total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL miss_hit got=%0b exp=0", bus.o_IF_Hit); end
    total++; if (bus.o_IF_Target !== 32'h0) begin bad++; $display("FAIL miss_target got=%h exp=0", bus.o_IF_Target); end
    sb.push_back('{1'b0, 32'h0, 2'b00});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL miss_reg got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
  endtask

  task automatic test_write_hit();
    drive(32'h40, 1, 32'h44, 32'h100, 2'b11);
    total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL wr_other_idx_hit got=%0b exp=0", bus.o_IF_Hit); end
    sb.push_back('{1'b0, 32'h0, 2'b00});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL wr_reg0 got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    drive(32'h44, 0, 32'h0, 32'h0, 2'b00);
    total++; if (bus.o_IF_Hit !== 1'b1) begin bad++; $display("FAIL wr_hit got=%0b exp=1", bus.o_IF_Hit); end
    total++; if (bus.o_IF_Target !== 32'h100) begin bad++; $display("FAIL wr_target got=%h exp=100", bus.o_IF_Target); end
    sb.push_back('{1'b1, 32'h100, 2'b11});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL wr_reg1 got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
  endtask

  task automatic test_alias();
    drive(32'h84, 0, 32'h0, 32'h0, 2'b00);
    total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL alias_miss got=%0b exp=0", bus.o_IF_Hit); end
    sb.push_back('{1'b0, 32'h0, 2'b00});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL alias_reg0 got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    drive(32'h84, 1, 32'h84, 32'h200, 2'b01);
    total++; if (bus.o_IF_Target !== 32'h200) begin bad++; $display("FAIL alias_wf_target got=%h exp=200", bus.o_IF_Target); end
    sb.push_back('{1'b1, 32'h200, 2'b01});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL alias_reg1 got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    drive(32'h44, 0, 32'h0, 32'h0, 2'b00);
    total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL alias_evict got=%0b exp=0", bus.o_IF_Hit); end
    sb.push_back('{1'b0, 32'h0, 2'b00});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL alias_reg2 got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
  endtask

  task automatic test_write_first();
    drive(32'h48, 1, 32'h48, 32'h300, 2'b10);
    total++; if (bus.o_IF_Hit !== 1'b1) begin bad++; $display("FAIL wf_hit got=%0b exp=1", bus.o_IF_Hit); end
    total++; if (bus.o_IF_Target !== 32'h300) begin bad++; $display("FAIL wf_target got=%h exp=300", bus.o_IF_Target); end
    sb.push_back('{1'b1, 32'h300, 2'b10});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL wf_reg got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] pcs [3];
    pcs[0] = 32'h84; pcs[1] = 32'h40; pcs[2] = 32'h100;
    drive(32'h48, 0, 32'h0, 32'h0, 2'b00);
    sb.push_back('{1'b1, 32'h300, 2'b10});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL stall_pre got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    bus.i_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(pcs[i], 0, 32'h0, 32'h0, 2'b00);
      sb.push_back('{1'b1, 32'h300, 2'b10});
      tick();
      e = sb.pop_front();
      total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
        begin bad++; $display("FAIL stall_hold%0d got=%0b/%h/%b exp=%0b/%h/%b", i, bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    end
    bus.i_Flush = 1'b1;
    drive(32'h84, 0, 32'h0, 32'h0, 2'b00);
    sb.push_back('{1'b0, 32'h0, 2'b00});
    tick();
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL flush_over_stall got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    bus.i_Flush = 1'b0;
    bus.i_Stall = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] fill [4];
    int n;
    fill[0] = 32'h40; fill[1] = 32'h44; fill[2] = 32'h48; fill[3] = 32'h4C;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 1, fill[i], 32'h1000 + i, 2'(i));
      sb.push_back('{1'b0, 32'h0, 2'b00});
      tick();
      e = sb.pop_front();
      total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
        begin bad++; $display("FAIL fill_reg%0d got=%0b/%h/%b exp=%0b/%h/%b", i, bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    end
    bus.i_Invalidate = 1'b1;
    drive(32'h4C, 1, 32'h50, 32'h2000, 2'b11);
    total++; if (bus.o_IF_Target !== 32'h1003) begin bad++; $display("FAIL pre_sweep_target got=%h exp=1003", bus.o_IF_Target); end
    sb.push_back('{1'b1, 32'h1003, 2'b11});
    tick();
    bus.i_Invalidate = 1'b0;
    e = sb.pop_front();
    total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
      begin bad++; $display("FAIL pre_sweep_reg got=%0b/%h/%b exp=%0b/%h/%b", bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    n = 0;
    while (bus.o_Busy === 1'b1 && n < 40) begin
      bus.i_Invalidate = (n == 3);
      drive(32'h4C, 1, 32'h54, 32'h3000, 2'b01);
      total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL sweep_hit%0d got=%0b exp=0", n, bus.o_IF_Hit); end
      sb.push_back('{1'b0, 32'h0, 2'b00});
      tick();
      e = sb.pop_front();
      total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
        begin bad++; $display("FAIL sweep_reg%0d got=%0b/%h/%b exp=%0b/%h/%b", n, bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
      n++;
    end
    bus.i_Invalidate = 1'b0;
    total++; if (n != 16) begin bad++; $display("FAIL busy_cycles got=%0d exp=16", n); end
    for (int i = 0; i < 6; i++) begin
      drive(32'h40 + 4 * i, 0, 32'h0, 32'h0, 2'b00);
      total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL post_sweep_miss%0d got=%0b exp=0", i, bus.o_IF_Hit); end
      sb.push_back('{1'b0, 32'h0, 2'b00});
      tick();
      e = sb.pop_front();
      total++; if ({bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn} !== e)
        begin bad++; $display("FAIL post_sweep_reg%0d got=%0b/%h/%b exp=%0b/%h/%b", i, bus.o_PcMatchValid, bus.o_PredTarget, bus.o_CtrlIn, e.v, e.t, e.c); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive(32'h60, 1, 32'h60, 32'h4000, 2'b10);
    tick();
    bus.i_Invalidate = 1'b1;
    drive(32'h60, 0, 32'h0, 32'h0, 2'b00);
    tick();
    bus.i_Invalidate = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (bus.o_Busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy got=%0b exp=1", bus.o_Busy); end
    rst = 1'b1;
    #1;
    total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL rst_sweep_busy got=%0b exp=0", bus.o_Busy); end
    total++; if (bus.o_PcMatchValid !== 1'b0) begin bad++; $display("FAIL rst_sweep_match got=%0b exp=0", bus.o_PcMatchValid); end
    sb.delete();
    tick();
    rst = 1'b0;
    drive(32'h60, 0, 32'h0, 32'h0, 2'b00);
    total++; if (bus.o_IF_Hit !== 1'b0) begin bad++; $display("FAIL rst_cleared_valid got=%0b exp=0", bus.o_IF_Hit); end
    drive(32'h64, 1, 32'h64, 32'h5000, 2'b01);
    total++; if (bus.o_IF_Target !== 32'h5000) begin bad++; $display("FAIL rst_idle_write got=%h exp=5000", bus.o_IF_Target); end
    tick();
    drive(32'h0, 0, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_miss();
    test_write_hit();
    test_alias();
    test_write_first();
    test_stall_flush();
    test_sweep();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter: ENTRIES, 16, number of direct-mapped entries (power of two, 4..64).
REQ-002 Parameter: PC_W, 32, program-counter and target width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: i_IF_PC  input  PC_W  fetch-stage PC to look up.
REQ-006 Port: i_Stall  input  1  IF/ID stall (driven from o_IFID_Stall); holds registered lookup outputs.
REQ-007 Port: i_Flush  input  1  IF/ID flush (driven from Flush_IF_ID); clears registered lookup outputs.
REQ-008 Port: o_IF_Hit  output  1  combinational hit for i_IF_PC, used by the fetch PC mux.
REQ-009 Port: o_IF_Target  output  PC_W  combinational predicted target for i_IF_PC.
REQ-010 Port: o_PcMatchValid  output  1  registered hit flag, aligned with the instruction in ID.
REQ-011 Port: o_PredTarget  output  PC_W  registered predicted target, aligned with ID.
REQ-012 Port: o_CtrlIn  output  2  registered 2-bit counter of the hit entry, aligned with ID.
REQ-013 Port: i_WriteEnable  input  1  update strobe from the branch unit.
REQ-014 Port: i_UpdPC  input  PC_W  PC of the resolved branch/jump.
REQ-015 Port: i_UpdTarget  input  PC_W  resolved target.
REQ-016 Port: i_CtrlOut  input  2  new counter value from the branch unit.
REQ-017 Port: i_Invalidate  input  1  one-cycle request to clear all entries.
REQ-018 Port: o_Busy  output  1  high while an invalidation sweep is in progress.

Function
REQ-019 Index = PC[log2(ENTRIES)+1:2]; tag = PC[PC_W-1:log2(ENTRIES)+2]; each entry holds valid, tag, target (PC_W), counter (2).
REQ-020 Hit = entry valid AND stored tag equals tag of i_IF_PC AND FSM in IDLE; on miss o_IF_Target = 0.
REQ-021 Lookup is write-first: if i_WriteEnable in IDLE targets the same index as i_IF_PC in that cycle, o_IF_Hit/o_IF_Target reflect the new data.
REQ-022 Registered outputs: on each edge, priority i_Flush (clear all to 0) > i_Stall (hold) > capture o_IF_Hit, o_IF_Target, and the hit entry's counter (00 on miss); latency exactly 1 cycle.
REQ-023 Update: when i_WriteEnable=1 in IDLE, entry[index(i_UpdPC)] SHALL be written with valid=1, tag, i_UpdTarget, i_CtrlOut, overwriting any existing entry (hit or alias).
REQ-024 FSM states IDLE and SWEEP; IDLE->SWEEP on i_Invalidate=1; SWEEP clears valid of entry sweep_idx each cycle, sweep_idx counting 0..ENTRIES-1; SWEEP->IDLE on the edge that clears entry ENTRIES-1.
REQ-025 o_Busy = 1 exactly while in SWEEP (ENTRIES cycles); i_Invalidate while in SWEEP is ignored (no restart).
REQ-026 While in SWEEP, i_WriteEnable is ignored and all lookups miss; the registered stage still obeys REQ-022.
REQ-027 If i_Invalidate and i_WriteEnable coincide in IDLE, the write is discarded and the sweep starts.
REQ-028 sweep_idx wraps to 0 on return to IDLE; no counter arithmetic on the 2-bit field (stored as given).

Reset
REQ-029 Asserting rst at any time, including mid-sweep, SHALL immediately force all valid bits to 0, FSM to IDLE, sweep_idx to 0, o_Busy to 0, o_PcMatchValid to 0, o_PredTarget to 0, o_CtrlIn to 00.
REQ-030 Tag, target, and counter storage need not be reset; outputs never expose them while valid=0.

Verification
REQ-031 Reset, then lookup 0x0000_0040 -> o_IF_Hit=0; next cycle o_PcMatchValid=0, o_CtrlIn=00.
REQ-032 Write PC 0x0000_0044, target 0x0000_0100, CtrlOut 11; next cycle lookup 0x0000_0044 -> o_IF_Hit=1, o_IF_Target=0x100; one cycle later o_PcMatchValid=1, o_CtrlIn=11.
REQ-033 Alias: after REQ-032, lookup 0x0000_0084 (same index, different tag) -> miss; write 0x84 then lookup 0x44 -> miss.
REQ-034 Same-cycle write and lookup of 0x0000_0048 -> o_IF_Hit=1 in that cycle (write-first).
REQ-035 Stall held 3 cycles keeps o_PredTarget constant while i_IF_PC changes; Flush with Stall both high -> registered outputs 0 next cycle.
REQ-036 Fill 4 entries, pulse i_Invalidate -> o_Busy high exactly 16 cycles, writes ignored during sweep, all lookups miss afterwards; rst at sweep cycle 5 -> o_Busy=0 immediately.
